// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: walks a one-hot digit select at a fixed rate
// and drives decoded segments, swapping in newly loaded values only at frame boundaries.
module seg7_scan_driver #(
  parameter int clk_mhz   = 50,
  parameter int w_digit   = 8,
  parameter int update_hz = 1000,
  parameter int lz_blank  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic                   load,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   scan_tick
);

  localparam int PERIOD = clk_mhz * 1_000_000 / update_hz;
  localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int IW     = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PERIOD - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(w_digit - 1);

  if (PERIOD < 2) begin : g_period_check
    $error("seg7_scan_driver: clk_mhz*1e6/update_hz must be at least 2");
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nib_at(input logic [4*w_digit-1:0] num, input logic [IW-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < w_digit; j++)
      if (j == int'(i)) r = num[4*j +: 4];
    return r;
  endfunction

  function automatic logic dot_at(input logic [w_digit-1:0] d, input logic [IW-1:0] i);
    logic r;
    r = 1'b0;
    for (int j = 0; j < w_digit; j++)
      if (j == int'(i)) r = d[j];
    return r;
  endfunction

  // A digit is dark when it and every more-significant digit are zero; digit 0 always shows.
  function automatic logic blank_digit(input logic [4*w_digit-1:0] num, input logic [IW-1:0] i);
    logic nonzero;
    nonzero = 1'b0;
    for (int j = 0; j < w_digit; j++)
      if (j >= int'(i) && num[4*j +: 4] != 4'h0) nonzero = 1'b1;
    return (lz_blank != 0) && (i != '0) && !nonzero;
  endfunction

  logic [PW-1:0]        presc;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 tick, wrap;
  logic [4*w_digit-1:0] pend_num, disp_num, disp_num_nxt;
  logic [w_digit-1:0]   pend_dots, disp_dots, disp_dots_nxt;
  logic [w_digit-1:0]   digit_nxt;
  logic [7:0]           seg_nxt;

  always_comb begin
    tick          = (presc == PRESC_MAX);
    wrap          = tick && (idx == IDX_MAX);
    idx_nxt       = idx;
    disp_num_nxt  = disp_num;
    disp_dots_nxt = disp_dots;
    if (wrap) idx_nxt = '0;
    else if (tick) idx_nxt = idx + IW'(1);
    if (wrap) begin
      disp_num_nxt  = load ? number : pend_num;
      disp_dots_nxt = load ? dots   : pend_dots;
    end
  end

  // Decode works on the post-edge display so digit 0 of a new frame shows the new value.
  always_comb begin
    digit_nxt = '0;
    for (int j = 0; j < w_digit; j++)
      if (j == int'(idx_nxt)) digit_nxt[j] = 1'b1;
    seg_nxt[7:1] = blank_digit(disp_num_nxt, idx_nxt) ? 7'b0
                                                      : seg_decode(nib_at(disp_num_nxt, idx_nxt));
    seg_nxt[0]   = dot_at(disp_dots_nxt, idx_nxt);
  end

  // Stage p0 -> p1: timing/frame state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      pend_num  <= '0;
      pend_dots <= '0;
      disp_num  <= '0;
      disp_dots <= '0;
      scan_tick <= 1'b0;
      digit     <= w_digit'(1);
      abcdefgh  <= 8'h00;
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      idx       <= idx_nxt;
      disp_num  <= disp_num_nxt;
      disp_dots <= disp_dots_nxt;
      scan_tick <= tick;
      if (load) begin
        pend_num  <= number;
        pend_dots <= dots;
      end
      if (tick) begin
        digit    <= digit_nxt;
        abcdefgh <= seg_nxt;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter clk_mhz, default 50, input clock frequency in MHz.
REQ-002 SHALL have parameter w_digit, default 8, number of display digits.
REQ-003 SHALL have parameter update_hz, default 1000, digit advance rate in Hz.
REQ-004 SHALL have parameter lz_blank, default 1; when 1, leading-zero blanking is enabled.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port number, input, 4*w_digit, hex nibbles; nibble i = number[4i+3:4i]; digit 0 is rightmost.
REQ-008 SHALL have port dots, input, w_digit, decimal point request per digit.
REQ-009 SHALL have port load, input, 1, strobe capturing number/dots into the pending register.
REQ-010 SHALL have port abcdefgh, output, 8, registered segments, active-high; bit7=a ... bit1=g, bit0=h (dp).
REQ-011 SHALL have port digit, output, w_digit, registered one-hot digit select, active-high.
REQ-012 SHALL have port scan_tick, output, 1, one-cycle pulse, registered, on each digit advance.

Function
REQ-013 SHALL compute period = clk_mhz*1_000_000/update_hz; period < 2 is an elaboration error.
REQ-014 SHALL run prescaler 0..period-1, width $clog2(period); tick asserted combinationally when prescaler == period-1; prescaler wraps to 0 on tick.
REQ-015 SHALL hold digit index idx 0..w_digit-1; idx increments on tick; idx == w_digit-1 with tick wraps to 0 (frame wrap).
REQ-016 SHALL capture number/dots into pending on any cycle with load=1; load=0 holds pending.
REQ-017 SHALL copy pending into display register only on frame wrap cycle (no tearing mid-frame).
REQ-018 SHALL, if load=1 on the frame wrap cycle, load display directly from number/dots (same cycle as pending).
REQ-019 SHALL register digit = one-hot(next idx) and abcdefgh = decode(next idx) in the same cycle, one cycle after tick; scan_tick registered from tick.
REQ-020 SHALL decode nibble a-g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-021 SHALL set h = display dots[idx].
REQ-022 SHALL, when lz_blank=1, force a-g to 0 for digit i>0 if all display nibbles j>=i are 0; digit 0 never blanked; h unaffected.
REQ-023 SHALL source the decode for the newly selected digit from the display register value valid after the same clock edge's frame-wrap update (digit 0 of a new frame shows the new value).
REQ-024 SHALL keep outputs stable between ticks; load alone changes no output.

Reset
REQ-025 SHALL, on rst asserted, asynchronously clear prescaler, idx=0, pending=0, display=0, scan_tick=0, digit='b1, abcdefgh=0.
REQ-026 SHALL, after rst release, start counting on the first clk edge; first tick occurs period cycles after release.
REQ-027 SHALL, on rst mid-frame, discard pending and display contents; no partial frame resumes.

Verification
REQ-028 Bench (clk_mhz=1, update_hz=250000, period=4, w_digit=4): release reset -> scan_tick every 4 cycles; digit 0001,0010,0100,1000,0001.
REQ-029 load number=16'h12AF, dots=0, wait frame wrap -> digit0 abcdefgh=10001110, digit1=11101110, digit2=11011010, digit3=01100000.
REQ-030 lz_blank=1, number=16'h0050 -> digit3,digit2 abcdefgh=00000000, digit1=10110110, digit0=11111100; number=0 -> only digit0 lit 11111100.
REQ-031 load 16'h1111 then 16'h2222 at idx=1 mid-frame -> digits 2,3 of current frame still show 1 (01100000); next frame all show 2 (11011010).
REQ-032 load=1 exactly on frame wrap cycle with 16'h8888, dots=4'b0101 -> new frame digit0 shows 11111111, digit1 11111110.
REQ-033 assert rst while idx=2 -> same cycle digit=0001, abcdefgh=0, scan_tick=0; after release first scan_tick after 4 cycles.
